mdu_hilo_ctrl: RTL and testbench
================================

// Module: mdu_hilo_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the 5-stage MIPS core.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, holds operands for a fixed latency and commits HI/LO.
//  Raises a stall to ID whenever an instruction there touches HI/LO while an operation is pending.
//  Feeds the HI/LO select mux and the EX->MEM forwarding paths.
// PARAMETERS
//  MULT_LAT  5   cycles from accepted MULT/MULTU to HI/LO commit (>=1)
//  DIV_LAT   10  cycles from accepted DIV/DIVU to HI/LO commit (>=1)
// PORTS
//  clk        in   1   core clock, all state on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   EX holds a valid md instruction this cycle
//  md_op      in   3   operation code (see mdu_pkg), sampled with start
//  cancel     in   1   exception/flush in EX this cycle; kills start
//  rs_val     in   32  forwarded RS operand (ALU_RD1)
//  rt_val     in   32  forwarded RT operand (ALU_RD2)
//  md_use_id  in   1   ID instruction is mult/div/mfhi/mflo/mthi/mtlo
//  busy       out  1   operation in flight
//  stall      out  1   freeze PC/IF/ID, bubble into EX
//  hi         out  32  HI register
//  lo         out  32  LO register
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, cnt=0, busy=0, hi=lo=0, latched operands=0.
//  stall = md_use_id & (busy | (start & ~cancel & op is MULT/MULTU/DIV/DIVU)); purely combinational.
//  FSM IDLE/MUL/DIV; accept = start & ~cancel & state==IDLE.
//   IDLE + accept + MULT/MULTU: latch rs,rt,signedness; cnt<=MULT_LAT-1; ->MUL.
//   IDLE + accept + DIV/DIVU:   latch likewise; cnt<=DIV_LAT-1; ->DIV.
//   IDLE + accept + MTHI: hi<=rs_val next edge; MTLO: lo<=rs_val; stay IDLE, busy stays 0.
//   MUL/DIV: cnt decrements each cycle; edge at cnt==0 commits and ->IDLE.
//  Timing: start at cycle 0 -> busy=1 cycles 1..LAT; new hi/lo and busy=0 visible in cycle LAT+1.
//  MULT: {hi,lo}=signed 64-bit rs*rt; MULTU unsigned 64-bit product.
//  DIV: lo=signed quotient, hi=signed remainder (sign of dividend, truncation toward zero);
//   DIVU unsigned. Divisor 0: hi/lo unchanged, latency unchanged.
//   0x80000000 / -1 signed: lo=0x80000000, hi=0.
//  start while busy: ignored (pipeline stall prevents it); simulation assertion fires.
//  cancel with start: no latch, no write, state unchanged. cancel while busy: no effect (op committed).
//  Unknown md_op with start: treated as no-op.
//  rst_n low mid-operation: abort immediately, all outputs to reset values, no partial commit.
//  hi/lo change only at commit edge or MTHI/MTLO edge; no intermediate values ever visible.
// STRUCTURE
//  mdu_pkg: md_op encodings (MD_NONE=0,MULT=1,MULTU=2,DIV=3,DIVU=4,MTHI=5,MTLO=6),
//   state encodings, MULT_LAT/DIV_LAT defaults.
//  Single module; arithmetic written as registered-operand * and / / % in commit logic;
//   no sub-module needed (iterative divider may later be split out as mdu_div_iter).
// TESTING
//  MULT rs=0xFFFFFFFE rt=3 -> busy cycles 1..5; cycle 6 hi=0xFFFFFFFF lo=0xFFFFFFFA.
//  MULTU rs=0xFFFFFFFF rt=2 -> hi=0x00000001 lo=0xFFFFFFFE after 5 busy cycles.
//  DIV rs=-7 rt=2 -> 10 busy cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged.
//  MULT then md_use_id=1 (mflo) in cycles 0..5 -> stall=1 exactly those cycles, 0 in cycle 6.
//  start+cancel with DIV -> busy stays 0, hi/lo unchanged; MTHI 0x1234 -> hi=0x1234 next cycle.
//  rst_n pulsed low at busy cycle 3 of MULT -> busy=0, hi=lo=0 immediately, no later commit.

Source files
------------

// File: rtl/mdu_hilo_ctrl_pkg.sv
// rtl/mdu_hilo_ctrl_pkg.sv - shared encodings and defaults for the HI/LO multiply/divide sequencer
// Contents: md_op encodings, FSM state encodings, default latencies, op-class helper.
package mdu_hilo_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // Multi-cycle operations; MTHI/MTLO complete in one edge and never occupy the unit.
    function automatic logic is_arith(logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_hilo_ctrl_if.sv
// rtl/mdu_hilo_ctrl_if.sv - EX/ID side bundle of the HI/LO multiply/divide sequencer
// Signals: start/md_op/cancel/rs_val/rt_val (EX request), md_use_id (ID query),
//          busy/stall (status), hi/lo (HI/LO register values).
// Modports: master = pipeline side, slave = sequencer side.
interface mdu_hilo_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic        cancel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_id;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, cancel, rs_val, rt_val, md_use_id,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, md_op, cancel, rs_val, rt_val, md_use_id,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/mdu_hilo_ctrl.sv
// rtl/mdu_hilo_ctrl.sv - multi-cycle multiply/divide sequencer owning the HI/LO register pair
// Ports: clk, rst_n (async active-low), md (mdu_hilo_ctrl_if.slave: EX request, ID hazard
//        query, busy/stall status, hi/lo values).
// Parameters: MULT_LAT, DIV_LAT = cycles from accepted start to HI/LO commit (>= 1).
import mdu_hilo_ctrl_pkg::*;

module mdu_hilo_ctrl #(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mdu_hilo_ctrl_if.slave        md
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sgn_q, sgn_d;
    logic [31:0]       rs_q, rs_d;
    logic [31:0]       rt_q, rt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              busy_q, busy_d;

    logic              accept;

    // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the product are
    // then correct for both signed and unsigned forms.
    logic [63:0]       mul_a, mul_b, mul_p;

    // Divide: one unsigned divider on magnitudes, signs restored afterwards. This also
    // makes 0x80000000 / -1 fall out naturally as quotient 0x80000000, remainder 0.
    logic              neg_a, neg_b, div_zero;
    logic [31:0]       mag_a, mag_b, mag_b_safe;
    logic [31:0]       quo_mag, rem_mag, quo, rem;

    assign accept = md.start && !md.cancel && (state_q == ST_IDLE);

    assign mul_a = {{32{sgn_q & rs_q[31]}}, rs_q};
    assign mul_b = {{32{sgn_q & rt_q[31]}}, rt_q};
    assign mul_p = mul_a * mul_b;

    assign neg_a      = sgn_q & rs_q[31];
    assign neg_b      = sgn_q & rt_q[31];
    assign mag_a      = neg_a ? (32'd0 - rs_q) : rs_q;
    assign mag_b      = neg_b ? (32'd0 - rt_q) : rt_q;
    assign div_zero   = (rt_q == 32'd0);
    // Divisor 0 never commits; a dummy divisor keeps the arithmetic well defined.
    assign mag_b_safe = div_zero ? 32'd1 : mag_b;
    assign quo_mag    = mag_a / mag_b_safe;
    assign rem_mag    = mag_a % mag_b_safe;
    assign quo        = (neg_a ^ neg_b) ? (32'd0 - quo_mag) : quo_mag;
    assign rem        = neg_a ? (32'd0 - rem_mag) : rem_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (md.md_op)
                        MD_MULT, MD_MULTU: begin
                            rs_d    = md.rs_val;
                            rt_d    = md.rt_val;
                            sgn_d   = (md.md_op == MD_MULT);
                            cnt_d   = MUL_CNT_INIT;
                            state_d = ST_MUL;
                            busy_d  = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            rs_d    = md.rs_val;
                            rt_d    = md.rt_val;
                            sgn_d   = (md.md_op == MD_DIV);
                            cnt_d   = DIV_CNT_INIT;
                            state_d = ST_DIV;
                            busy_d  = 1'b1;
                        end
                        MD_MTHI: hi_d = md.rs_val;
                        MD_MTLO: lo_d = md.rs_val;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    hi_d    = mul_p[63:32];
                    lo_d    = mul_p[31:0];
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (cnt_q == '0) begin
                    if (!div_zero) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    // Stall also covers the cycle an arithmetic op is being issued, since busy is
    // only visible from the following cycle.
    assign md.stall = md.md_use_id && (busy_q || (md.start && !md.cancel && is_arith(md.md_op)));
    assign md.busy  = busy_q;
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;

    // The pipeline stall is supposed to keep EX from issuing while an op is in flight.
    start_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(md.start && !md.cancel && busy_q));

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// tb/tb_mdu_hilo_ctrl.sv - directed self-checking bench for mdu_hilo_ctrl
import mdu_hilo_ctrl_pkg::*;

module tb_mdu_hilo_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mdu_hilo_ctrl_if md_if ();

    mdu_hilo_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Enter a new cycle and present a request in it (cycle 0 of that op).
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        md_if.start  = 1'b1;
        md_if.md_op  = op;
        md_if.rs_val = a;
        md_if.rt_val = b;
    endtask

    task automatic next_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            md_if.start  = 1'b0;
            md_if.cancel = 1'b0;
            md_if.md_op  = MD_NONE;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n            = 1'b0;
        md_if.start      = 1'b0;
        md_if.md_op      = MD_NONE;
        md_if.cancel     = 1'b0;
        md_if.rs_val     = '0;
        md_if.rt_val     = '0;
        md_if.md_use_id  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(md_if.busy), 32'd0);
        chk("rst_stall", 32'(md_if.stall), 32'd0);
        chk("rst_hi", md_if.hi, 32'd0);
        chk("rst_lo", md_if.lo, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // MULT -2 * 3 with mflo in ID throughout: stall cycles 0..5, commit in cycle 6
        md_if.md_use_id = 1'b1;
        start_op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        @(negedge clk);
        chk("mult_c0_stall", 32'(md_if.stall), 32'd1);
        chk("mult_c0_busy", 32'(md_if.busy), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            next_cycles(1);
            @(negedge clk);
            chk($sformatf("mult_c%0d_busy", c), 32'(md_if.busy), 32'd1);
            chk($sformatf("mult_c%0d_stall", c), 32'(md_if.stall), 32'd1);
            chk($sformatf("mult_c%0d_lo_hold", c), md_if.lo, 32'd0);
        end
        next_cycles(1);
        @(negedge clk);
        chk("mult_c6_busy", 32'(md_if.busy), 32'd0);
        chk("mult_c6_stall", 32'(md_if.stall), 32'd0);
        chk("mult_hi", md_if.hi, 32'hFFFF_FFFF);
        chk("mult_lo", md_if.lo, 32'hFFFF_FFFA);
        md_if.md_use_id = 1'b0;

        // MULTU 0xFFFFFFFF * 2
        start_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        next_cycles(5);
        @(negedge clk);
        chk("multu_c5_busy", 32'(md_if.busy), 32'd1);
        next_cycles(1);
        @(negedge clk);
        chk("multu_busy", 32'(md_if.busy), 32'd0);
        chk("multu_hi", md_if.hi, 32'h0000_0001);
        chk("multu_lo", md_if.lo, 32'hFFFF_FFFE);

        // DIV -7 / 2: 10 busy cycles, hi held until commit
        start_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        next_cycles(10);
        @(negedge clk);
        chk("div_c10_busy", 32'(md_if.busy), 32'd1);
        chk("div_c10_hi_hold", md_if.hi, 32'h0000_0001);
        next_cycles(1);
        @(negedge clk);
        chk("div_busy", 32'(md_if.busy), 32'd0);
        chk("div_lo", md_if.lo, 32'hFFFF_FFFD);
        chk("div_hi", md_if.hi, 32'hFFFF_FFFF);

        // DIVU 7 / 0: full latency, nothing written
        start_op(MD_DIVU, 32'd7, 32'd0);
        next_cycles(10);
        @(negedge clk);
        chk("divu0_c10_busy", 32'(md_if.busy), 32'd1);
        next_cycles(1);
        @(negedge clk);
        chk("divu0_busy", 32'(md_if.busy), 32'd0);
        chk("divu0_hi", md_if.hi, 32'hFFFF_FFFF);
        chk("divu0_lo", md_if.lo, 32'hFFFF_FFFD);

        // DIV 0x80000000 / -1 overflow case
        start_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        next_cycles(11);
        @(negedge clk);
        chk("divovf_lo", md_if.lo, 32'h8000_0000);
        chk("divovf_hi", md_if.hi, 32'h0000_0000);

        // DIV 7 / -2: quotient -3, remainder +1
        start_op(MD_DIV, 32'd7, 32'hFFFF_FFFE);
        next_cycles(11);
        @(negedge clk);
        chk("divneg_lo", md_if.lo, 32'hFFFF_FFFD);
        chk("divneg_hi", md_if.hi, 32'h0000_0001);

        // DIVU 100 / 7 unsigned
        start_op(MD_DIVU, 32'd100, 32'd7);
        next_cycles(11);
        @(negedge clk);
        chk("divu_lo", md_if.lo, 32'd14);
        chk("divu_hi", md_if.hi, 32'd2);

        // start + cancel with DIV: no stall, never busy, hi/lo untouched
        md_if.md_use_id = 1'b1;
        start_op(MD_DIV, 32'd100, 32'd3);
        md_if.cancel = 1'b1;
        @(negedge clk);
        chk("cancel_c0_stall", 32'(md_if.stall), 32'd0);
        next_cycles(1);
        @(negedge clk);
        chk("cancel_busy", 32'(md_if.busy), 32'd0);
        next_cycles(10);
        @(negedge clk);
        chk("cancel_hi", md_if.hi, 32'd2);
        chk("cancel_lo", md_if.lo, 32'd14);

        // Unknown op: no-op, no stall
        start_op(3'd7, 32'hDEAD_BEEF, 32'h1);
        @(negedge clk);
        chk("unk_stall", 32'(md_if.stall), 32'd0);
        next_cycles(1);
        @(negedge clk);
        chk("unk_busy", 32'(md_if.busy), 32'd0);
        chk("unk_hi", md_if.hi, 32'd2);
        chk("unk_lo", md_if.lo, 32'd14);
        md_if.md_use_id = 1'b0;

        // MTHI / MTLO: visible the next cycle, never busy
        start_op(MD_MTHI, 32'h0000_1234, 32'h0);
        next_cycles(1);
        @(negedge clk);
        chk("mthi_hi", md_if.hi, 32'h0000_1234);
        chk("mthi_lo", md_if.lo, 32'd14);
        chk("mthi_busy", 32'(md_if.busy), 32'd0);
        start_op(MD_MTLO, 32'h0000_5678, 32'h0);
        next_cycles(1);
        @(negedge clk);
        chk("mtlo_lo", md_if.lo, 32'h0000_5678);
        chk("mtlo_hi", md_if.hi, 32'h0000_1234);

        // cancel while busy has no effect on the committed op
        start_op(MD_MULT, 32'd3, 32'd4);
        next_cycles(2);
        md_if.cancel = 1'b1;
        next_cycles(4);
        @(negedge clk);
        chk("cancel_busy_lo", md_if.lo, 32'd12);
        chk("cancel_busy_hi", md_if.hi, 32'd0);

        // Reset asserted in busy cycle 3: immediate clear, no later commit
        start_op(MD_MTHI, 32'h0000_AAAA, 32'h0);
        next_cycles(1);
        start_op(MD_MULT, 32'd5, 32'd7);
        next_cycles(3);
        @(negedge clk);
        chk("rstmid_c3_busy", 32'(md_if.busy), 32'd1);
        chk("rstmid_c3_hi", md_if.hi, 32'h0000_AAAA);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(md_if.busy), 32'd0);
        chk("rstmid_hi", md_if.hi, 32'd0);
        chk("rstmid_lo", md_if.lo, 32'd0);
        next_cycles(1);
        rst_n = 1'b1;
        next_cycles(8);
        @(negedge clk);
        chk("rstmid_after_busy", 32'(md_if.busy), 32'd0);
        chk("rstmid_after_hi", md_if.hi, 32'd0);
        chk("rstmid_after_lo", md_if.lo, 32'd0);

        // Unit works again after reset
        start_op(MD_MULTU, 32'd6, 32'd7);
        next_cycles(6);
        @(negedge clk);
        chk("postrst_lo", md_if.lo, 32'd42);
        chk("postrst_hi", md_if.hi, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
